r8_mbn_pipe: RTL

Parametrised, pipelined radix-8 (Booth-3) multiplier for the b_box datapath, the successor to the fixed 8-bit signed radix-8 multiplier. It generalises operand width, adds a per-operation signed/unsigned mode, and carries a sideband tag. It uses a three-stage valid/ready pipeline with full back-pressure, so it can sit between the operand fetch and accumulation stages of the MAC array.

---
 rtl/r8mbn_pkg.sv | 46 ++++
 rtl/r8_pp_row.sv | 42 ++++
 rtl/r8_mbn_pipe.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/r8mbn_pkg.sv
// Shared definitions for the radix-8 Booth multiplier pipeline: group count and
// Booth-3 digit encoding.
package r8mbn_pkg;

   typedef enum logic [2:0] {
      MagZero,
      MagSingle,
      MagDouble,
      MagTriple,
      MagQuad
   } booth_mag_e;

   typedef struct packed {
      logic       neg;
      logic       nzero;
      booth_mag_e mag;
   } booth_dig_t;

   localparam booth_dig_t BoothPZero = '{neg: 1'b0, nzero: 1'b0, mag: MagZero};
   localparam booth_dig_t BoothNZero = '{neg: 1'b1, nzero: 1'b1, mag: MagZero};

   function automatic int unsigned group_cnt(input int unsigned width);
      return (width + 3) / 3;
   endfunction

   // grp = {x[3j+2], x[3j+1], x[3j], x[3j-1]}; digit = -4*g3 + 2*g2 + g1 + g0
   function automatic booth_dig_t booth3_encode(input logic [3:0] grp);
      booth_dig_t d;
      d = BoothPZero;
      case (grp)
         4'b0000:          d = BoothPZero;
         4'b0001, 4'b0010: d = '{neg: 1'b0, nzero: 1'b0, mag: MagSingle};
         4'b0011, 4'b0100: d = '{neg: 1'b0, nzero: 1'b0, mag: MagDouble};
         4'b0101, 4'b0110: d = '{neg: 1'b0, nzero: 1'b0, mag: MagTriple};
         4'b0111:          d = '{neg: 1'b0, nzero: 1'b0, mag: MagQuad};
         4'b1000:          d = '{neg: 1'b1, nzero: 1'b0, mag: MagQuad};
         4'b1001, 4'b1010: d = '{neg: 1'b1, nzero: 1'b0, mag: MagTriple};
         4'b1011, 4'b1100: d = '{neg: 1'b1, nzero: 1'b0, mag: MagDouble};
         4'b1101, 4'b1110: d = '{neg: 1'b1, nzero: 1'b0, mag: MagSingle};
         4'b1111:          d = BoothNZero;
         default:          d = BoothPZero;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/r8_pp_row.sv
// One Booth-3 digit encoder plus its multiple selector; emits the row in one's-complement
// form with the sign bit split out for the sign-extension constant scheme.
module r8_pp_row
   import r8mbn_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [3:0]       grp_i,
   input  logic [WIDTH:0]   y_i,
   input  logic [WIDTH+2:0] y3_i,
   output logic [WIDTH+1:0] pp_o,
   output logic             neg_o,
   output logic             e_o
);

   booth_dig_t       dig;
   logic [WIDTH+2:0] y_ext;
   logic [WIDTH+2:0] mag;
   logic [WIDTH+2:0] row;

   assign dig   = booth3_encode(grp_i);
   assign y_ext = (WIDTH+3)'($signed(y_i));

   always_comb begin
      mag = '0;
      case (dig.mag)
         MagZero:   mag = '0;
         MagSingle: mag = y_ext;
         MagDouble: mag = y_ext << 1;
         MagTriple: mag = y3_i;
         MagQuad:   mag = y_ext << 2;
         default:   mag = '0;
      endcase
   end

   // -0 is kept positive so the row and its correction bit are both zero
   assign neg_o = dig.neg & ~dig.nzero;
   assign row   = neg_o ? ~mag : mag;
   assign pp_o  = row[WIDTH+1:0];
   assign e_o   = row[WIDTH+2];

endmodule

// File: rtl/r8_mbn_pipe.sv
// Three-stage radix-8 Booth multiplier with valid/ready back-pressure:
// S1 extends operands and forms 3Y, S2 recodes and compresses to sum/carry, S3 adds.
module r8_mbn_pipe
   import r8mbn_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned TAG_W = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_signed,
   input  logic [WIDTH-1:0]     in_mx,
   input  logic [WIDTH-1:0]     in_my,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product,
   output logic [TAG_W-1:0]     out_tag
);

   localparam int unsigned G  = group_cnt(WIDTH);
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned XW = 3 * G;
   localparam int unsigned YW = WIDTH + 3;

   // Sum of the -2^(W+2+3j) terms left over when each row's sign bit e is replaced by ~e
   function automatic logic [PW-1:0] sign_const();
      logic [PW-1:0] k;
      k = '0;
      for (int unsigned j = 0; j < G; j++) begin
         k = k - (PW'(1) << (WIDTH + 2 + 3 * j));
      end
      return k;
   endfunction

   localparam logic [PW-1:0] SignK = sign_const();

   logic en1, en2, en3;

   logic             v1_q, v2_q, v3_q;
   logic [WIDTH:0]   mx1_q, my1_q;
   logic [YW-1:0]    y3_1_q;
   logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
   logic [PW-1:0]    sum2_q, carry2_q, prod3_q;

   logic [WIDTH:0]   mx_ext, my_ext;
   logic [YW-1:0]    my_wide, y3_d;

   logic [XW-1:0]    x_ext;
   logic [XW:0]      xz;
   logic [WIDTH+1:0] pp [G];
   logic [G-1:0]     neg, e;
   logic [PW-1:0]    ops [G+1];
   logic [PW-1:0]    corr;
   logic [PW-1:0]    sum_d, carry_d;

   // Ready ripples back combinationally so a retiring full pipe still accepts
   assign en3      = !v3_q || out_ready;
   assign en2      = !v2_q || en3;
   assign en1      = !v1_q || en2;
   assign in_ready = en1;

   assign mx_ext  = {in_signed & in_mx[WIDTH-1], in_mx};
   assign my_ext  = {in_signed & in_my[WIDTH-1], in_my};
   assign my_wide = YW'($signed(my_ext));
   assign y3_d    = my_wide + (my_wide << 1);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         v1_q   <= 1'b0;
         mx1_q  <= '0;
         my1_q  <= '0;
         y3_1_q <= '0;
         tag1_q <= '0;
      end else if (en1) begin
         v1_q   <= in_valid;
         mx1_q  <= mx_ext;
         my1_q  <= my_ext;
         y3_1_q <= y3_d;
         tag1_q <= in_tag;
      end
   end

   assign x_ext = XW'($signed(mx1_q));
   assign xz    = {x_ext, 1'b0};

   for (genvar j = 0; j < G; j++) begin : g_row
      r8_pp_row #(
         .WIDTH (WIDTH)
      ) u_row (
         .grp_i (xz[3*j+3 -: 4]),
         .y_i   (my1_q),
         .y3_i  (y3_1_q),
         .pp_o  (pp[j]),
         .neg_o (neg[j]),
         .e_o   (e[j])
      );
      assign ops[j] = PW'({~e[j], pp[j]}) << (3 * j);
   end

   always_comb begin
      corr = '0;
      for (int unsigned j = 0; j < G; j++) begin
         corr[3*j] = neg[j];
      end
   end

   assign ops[G] = corr;

   // Carry-save accumulation; carry vector carries weight 2 relative to sum
   always_comb begin
      logic [PW-1:0] s, c, t;
      s = SignK;
      c = '0;
      t = '0;
      for (int unsigned j = 0; j <= G; j++) begin
         t = c << 1;
         c = (s & t) | (s & ops[j]) | (t & ops[j]);
         s = s ^ t ^ ops[j];
      end
      sum_d   = s;
      carry_d = c;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         v2_q     <= 1'b0;
         sum2_q   <= '0;
         carry2_q <= '0;
         tag2_q   <= '0;
      end else if (en2) begin
         v2_q     <= v1_q;
         sum2_q   <= sum_d;
         carry2_q <= carry_d;
         tag2_q   <= tag1_q;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         v3_q    <= 1'b0;
         prod3_q <= '0;
         tag3_q  <= '0;
      end else if (en3) begin
         v3_q    <= v2_q;
         prod3_q <= sum2_q + (carry2_q << 1);
         tag3_q  <= tag2_q;
      end
   end

   assign out_valid   = v3_q;
   assign out_product = prod3_q;
   assign out_tag     = tag3_q;

endmodule
